// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32 R-type / I-type ALU instructions into a small
// FIFO output buffer with valid/ready handshakes on both sides.
// Optional macro ENC_CHECK_EN: drop illegal I-type shift encodings and set a
// sticky err_o flag; without it err_o is tied 0 and every request is pushed.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     type_i,
    input  logic [6:0]               funct7_i,
    input  logic [2:0]               funct3_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [11:0]              imm_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [31:0]              instr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              issued_o,
    output logic                     err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [6:0]  OP_R = 7'b0110011;
    localparam logic [6:0]  OP_I = 7'b0010011;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   word;
    logic          accept;
    logic          illegal;
    logic          push;
    logic          pop;

    // Handshake status is derived from the registered occupancy only.
    assign req_ready_o   = (count_o != CW'(DEPTH));
    assign instr_valid_o = (count_o != CW'(0));
    assign instr_o       = instr_valid_o ? mem[rd_ptr] : 32'h0;

    assign accept = req_valid_i && req_ready_o;
    assign pop    = instr_valid_o && instr_ready_i;
    assign push   = accept && !illegal;

    // Instruction word formation for the two supported formats.
    always_comb begin
        word = 32'h0;
        if (type_i) begin
            word = {imm_i, rs1_i, funct3_i, rd_i, OP_I};
        end else begin
            word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
        end
    end

`ifdef ENC_CHECK_EN
    // Shift-immediate legality: SLLI needs imm[11:5]=0, SRLI/SRAI need 0 or 0x20.
    always_comb begin
        illegal = 1'b0;
        if (type_i) begin
            if (funct3_i == 3'b001 && imm_i[11:5] != 7'b0000000) begin
                illegal = 1'b1;
            end
            if (funct3_i == 3'b101 && imm_i[11:5] != 7'b0000000
                                   && imm_i[11:5] != 7'b0100000) begin
                illegal = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else if (accept && illegal) begin
            err_o <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Buffer storage; contents are don't-care while not counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Pointers, occupancy and pop counter; reset discards everything at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_o  <= '0;
            issued_o <= 16'h0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                issued_o <= issued_o + 16'd1;
            end
            if (push && !pop) begin
                count_o <= count_o + CW'(1);
            end else if (pop && !push) begin
                count_o <= count_o - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH = 4).
// Build with +define+ENC_CHECK_EN to exercise the legality check.
module tb_instr_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        type_i;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [11:0] imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [2:0]  count_o;
    logic [15:0] issued_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    instr_encoder #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .type_i(type_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .count_o(count_o), .issued_o(issued_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present an R-type request whose only nonzero field is rd.
    task automatic drive_r(input logic [4:0] rd);
        req_valid_i = 1'b1; type_i = 1'b0; funct7_i = 7'h0; funct3_i = 3'h0;
        rs1_i = 5'h0; rs2_i = 5'h0; imm_i = 12'h0; rd_i = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b0;
        drive_r(5'd0); req_valid_i = 1'b0;
        step(); step();
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count_o); end
        tests++; if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
        tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", req_ready_o); end
        tests++; if (instr_o !== 32'h0) begin fails++; $display("FAIL rst_instr got %h want 0", instr_o); end
        tests++; if (issued_o !== 16'h0) begin fails++; $display("FAIL rst_issued got %0d want 0", issued_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err_o); end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_rtype();
        req_valid_i = 1'b1; type_i = 1'b0; funct7_i = 7'h20; rs2_i = 5'd3;
        rs1_i = 5'd2; funct3_i = 3'd0; rd_i = 5'd1; imm_i = 12'hABC;
        step();
        req_valid_i = 1'b0;
        tests++; if (instr_o !== 32'h403100B3) begin fails++; $display("FAIL rtype_instr got %h want 403100b3", instr_o); end
        tests++; if (instr_valid_o !== 1'b1) begin fails++; $display("FAIL rtype_valid got %b want 1", instr_valid_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL rtype_count got %0d want 1", count_o); end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL rtype_pop_count got %0d want 0", count_o); end
        tests++; if (issued_o !== 16'd1) begin fails++; $display("FAIL rtype_issued got %0d want 1", issued_o); end
    endtask

    task automatic test_itype();
        req_valid_i = 1'b1; type_i = 1'b1; imm_i = 12'hFFF; rs1_i = 5'd0;
        funct3_i = 3'd0; rd_i = 5'd5; funct7_i = 7'h7F; rs2_i = 5'h1F;
        step();
        req_valid_i = 1'b0;
        tests++; if (instr_o !== 32'hFFF00293) begin fails++; $display("FAIL itype_instr got %h want fff00293", instr_o); end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        tests++; if (issued_o !== 16'd2) begin fails++; $display("FAIL itype_issued got %0d want 2", issued_o); end
        tests++; if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL itype_empty got %b want 0", instr_valid_o); end
    endtask

    // Words 0xB3,0x133,0x1B3,0x233 fill the buffer; 0x2B3 must wait for a slot.
    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive_r(5'(i + 1));
            tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL full_ready_%0d got %b want 1", i, req_ready_o); end
            step();
        end
        tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", req_ready_o); end
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", count_o); end
        drive_r(5'd5);
        step();
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL full_hold_count got %0d want 4", count_o); end
        tests++; if (instr_o !== 32'h000000B3) begin fails++; $display("FAIL full_hold_instr got %h want 000000b3", instr_o); end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL full_pop_count got %0d want 3", count_o); end
        tests++; if (instr_o !== 32'h00000133) begin fails++; $display("FAIL full_pop_instr got %h want 00000133", instr_o); end
        step();
        req_valid_i = 1'b0;
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL full_fifth_count got %0d want 4", count_o); end
        tests++; if (issued_o !== 16'd3) begin fails++; $display("FAIL full_issued got %0d want 3", issued_o); end
    endtask

    // Buffer holds 0x133,0x1B3,0x233,0x2B3; free one slot then stream push+pop.
    task automatic test_back_to_back();
        logic [31:0] heads [3];
        logic [31:0] tail  [3];
        heads[0] = 32'h233; heads[1] = 32'h2B3; heads[2] = 32'h333;
        tail[0]  = 32'h333; tail[1]  = 32'h3B3; tail[2]  = 32'h433;
        instr_ready_i = 1'b1;
        step();
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL b2b_free_count got %0d want 3", count_o); end
        tests++; if (instr_o !== 32'h1B3) begin fails++; $display("FAIL b2b_free_head got %h want 000001b3", instr_o); end
        for (int i = 0; i < 3; i++) begin
            drive_r(5'(i + 6));
            step();
            tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL b2b_count_%0d got %0d want 3", i, count_o); end
            tests++; if (instr_o !== heads[i]) begin fails++; $display("FAIL b2b_head_%0d got %h want %h", i, instr_o, heads[i]); end
        end
        req_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (instr_o !== tail[i]) begin fails++; $display("FAIL b2b_drain_%0d got %h want %h", i, instr_o, tail[i]); end
            instr_ready_i = 1'b1;
            step();
            instr_ready_i = 1'b0;
        end
        tests++; if (issued_o !== 16'd10) begin fails++; $display("FAIL b2b_issued got %0d want 10", issued_o); end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL empty_pop_count got %0d want 0", count_o); end
        tests++; if (issued_o !== 16'd10) begin fails++; $display("FAIL empty_pop_issued got %0d want 10", issued_o); end
        tests++; if (instr_o !== 32'h0) begin fails++; $display("FAIL empty_instr got %h want 0", instr_o); end
    endtask

    task automatic test_check();
        req_valid_i = 1'b1; type_i = 1'b1; funct3_i = 3'd1; imm_i = 12'h400;
        rs1_i = 5'd0; rd_i = 5'd0; funct7_i = 7'h0; rs2_i = 5'h0;
        step();
`ifdef ENC_CHECK_EN
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL chk_drop_count got %0d want 0", count_o); end
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL chk_err got %b want 1", err_o); end
        funct3_i = 3'd5;
        step();
        req_valid_i = 1'b0;
        tests++; if (instr_o !== 32'h40005013) begin fails++; $display("FAIL chk_srai_instr got %h want 40005013", instr_o); end
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL chk_err_sticky got %b want 1", err_o); end
`else
        req_valid_i = 1'b0;
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL chk_push_count got %0d want 1", count_o); end
        tests++; if (instr_o !== 32'h40001013) begin fails++; $display("FAIL chk_push_instr got %h want 40001013", instr_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL chk_err got %b want 0", err_o); end
`endif
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive_r(5'(i + 1));
            step();
        end
        req_valid_i = 1'b0;
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL arst_pre_count got %0d want 3", count_o); end
        #2;
        rst_i = 1'b0;
        #1;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL arst_count got %0d want 0", count_o); end
        tests++; if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL arst_valid got %b want 0", instr_valid_o); end
        tests++; if (instr_o !== 32'h0) begin fails++; $display("FAIL arst_instr got %h want 0", instr_o); end
        tests++; if (issued_o !== 16'h0) begin fails++; $display("FAIL arst_issued got %0d want 0", issued_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL arst_err got %b want 0", err_o); end
        step();
        rst_i = 1'b1;
        step();
        tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL arst_ready got %b want 1", req_ready_o); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_full();
        test_back_to_back();
        test_check();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of output-buffer entries; power of two, 2..16.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  encode request present.
REQ-005 SHALL have port req_ready_o  output  1  request accepted this cycle when high with req_valid_i.
REQ-006 SHALL have port type_i  input  1  0 = R-type ALU op, 1 = I-type ALU-immediate op.
REQ-007 SHALL have ports funct7_i  input  7, funct3_i  input  3, rd_i  input  5, rs1_i  input  5, rs2_i  input  5, imm_i  input  12; instruction fields.
REQ-008 SHALL have port instr_valid_o  output  1  instr_o holds a valid encoded instruction.
REQ-009 SHALL have port instr_ready_i  input  1  consumer takes instr_o when high with instr_valid_o.
REQ-010 SHALL have port instr_o  output  32  encoded instruction at buffer head.
REQ-011 SHALL have port count_o  output  clog2(DEPTH)+1  buffered entries.
REQ-012 SHALL have port issued_o  output  16  instructions popped since reset.
REQ-013 SHALL have port err_o  output  1  sticky illegal-request flag.

Function
REQ-014 R-type SHALL encode as {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011}.
REQ-015 I-type SHALL encode as {imm_i, rs1_i, funct3_i, rd_i, 7'b0010011}; funct7_i and rs2_i ignored.
REQ-016 Push SHALL occur when req_valid_i && req_ready_o; pop when instr_valid_o && instr_ready_i.
REQ-017 req_ready_o SHALL equal (count_o != DEPTH); instr_valid_o SHALL equal (count_o != 0).
REQ-018 Latency SHALL be one cycle: a word pushed at edge N drives instr_o after edge N, with no combinational input-to-output path.
REQ-019 Simultaneous push and pop SHALL leave count_o unchanged and preserve FIFO order.
REQ-020 Push when full SHALL not be possible; pop when empty SHALL be ignored.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 instr_o SHALL hold its value while instr_valid_o is high and instr_ready_i is low.
REQ-023 issued_o SHALL increment by one per pop and wrap from 16'hFFFF to 0.

Reset
REQ-024 While rst_i is low: buffer empty, count_o=0, instr_valid_o=0, req_ready_o=1, instr_o=32'h0, issued_o=0, err_o=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro ENC_CHECK_EN SHALL compile in a legality check: an I-type request with funct3_i of 3'b001 and imm_i[11:5] != 7'b0000000, or funct3_i of 3'b101 and imm_i[11:5] not in {7'b0000000, 7'b0100000}, is accepted but not pushed, and sets err_o until reset.
REQ-027 Without ENC_CHECK_EN, err_o SHALL be tied 0 and every accepted request SHALL be pushed unchanged.

Verification
REQ-028 R-type, funct7=0x20, rs2=3, rs1=2, funct3=0, rd=1 -> next cycle instr_o=32'h403100B3, instr_valid_o=1.
REQ-029 I-type, imm=0xFFF, rs1=0, funct3=0, rd=5 -> instr_o=32'hFFF00293.
REQ-030 Five pushes with instr_ready_i=0, DEPTH=4 -> req_ready_o=0 after the 4th, count_o=4, 5th held; then one pop -> 5th accepted.
REQ-031 Full buffer, push and pop in same cycle after one pop frees a slot -> count_o stays constant, output order matches input order, issued_o counts pops.
REQ-032 With ENC_CHECK_EN: I-type funct3=1, imm=0x400 -> count_o unchanged, err_o=1 until rst_i low.
REQ-033 Assert rst_i low asynchronously with 3 entries buffered -> count_o=0, instr_valid_o=0 before the next clock edge.
